reg16_move_sequencer: RTL and testbench

REG16_MOVE_SEQUENCER -- requirements
Module: reg16_move_sequencer

---
 rtl/reg16_move_sequencer_pkg.sv | 29 ++
 rtl/reg16_move_sequencer_seq_step_counter.sv | 45 ++++
 rtl/reg16_move_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_reg16_move_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg16_move_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reg16_move_sequencer_pkg
// Shared encodings for the 16-bit register-move sequencer: op modes, sequencer
// states, incrementer commands and the default PC/SP register-file indices.
// -----------------------------------------------------------------------------
package reg16_move_sequencer_pkg;

   typedef enum logic [1:0] {
      MODE_MOVE   = 2'b00,
      MODE_JUMP   = 2'b01,
      MODE_ADDOFF = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OPERAND = 2'd1,
      ST_EXECUTE = 2'd2,
      ST_FETCH   = 2'd3
   } state_e;

   localparam logic [1:0] INC_NONE = 2'b00;
   localparam logic [1:0] INC_UP   = 2'b01;
   localparam logic [1:0] INC_DOWN = 2'b10;

   localparam int DEFAULT_PC_INDEX = 4;
   localparam int DEFAULT_SP_INDEX = 3;

endpackage

// File: rtl/reg16_move_sequencer_seq_step_counter.sv
// -----------------------------------------------------------------------------
// seq_step_counter
// T-step counter inside one M-cycle. Counts 0..STEPS_PER_M-1 while running,
// wraps on the last step, and holds on the last step while stalled.
// Ports:
//   i_Clk, i_Reset : clock, async active-high reset
//   i_Run          : sequencer is busy (counter forced to 0 otherwise)
//   i_Stall        : hold on the last step (bus not ready)
//   o_Last         : current step is the last of the M-cycle
//   o_Advance      : last step completes this cycle; sequencer moves on
// -----------------------------------------------------------------------------
module seq_step_counter #(
   parameter  int STEPS_PER_M = 4,
   localparam int SW          = $clog2(STEPS_PER_M)
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Run,
   input  logic i_Stall,
   output logic o_Last,
   output logic o_Advance
);

   localparam logic [SW-1:0] LAST_STEP = SW'(STEPS_PER_M - 1);

   logic [SW-1:0] step_q;

   assign o_Last    = (step_q == LAST_STEP);
   assign o_Advance = i_Run && o_Last && !i_Stall;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         step_q <= '0;
      end else if (!i_Run) begin
         step_q <= '0;
      end else if (o_Last) begin
         if (!i_Stall) step_q <= '0;
      end else begin
         step_q <= step_q + SW'(1);
      end
   end

endmodule

// File: rtl/reg16_move_sequencer.sv
// -----------------------------------------------------------------------------
// reg16_move_sequencer
// Micro-sequencer for 16-bit register moves: MOVE (reg->reg), JUMP (reg->PC)
// and, when REG16_SEQ_ADDOFF_EN is defined, ADDOFF (SP + operand -> reg).
// Each op runs a fixed chain of M-cycles and always ends with an opcode FETCH.
// Configuration macro: REG16_SEQ_ADDOFF_EN (undefined: ADDOFF is illegal,
// o_Alu_Add_Off is 0 and the OPERAND state is never entered).
// Ports:
//   i_Clk, i_Reset        : clock, async active-high reset
//   i_Start, i_Mode       : op launch pulse and mode (00 MOVE/01 JUMP/10 ADDOFF)
//   i_Src, i_Dst          : source / destination register indices
//   i_Mem_Ready           : bus ready for the current address cycle
//   o_Busy                : sequence in progress
//   o_Read16, o_Write16   : one-hot register read / write selects
//   o_Address_Out         : selected register drives the address bus
//   o_Increment16         : 01 = +1, 10 = -1, 00 = none
//   o_Alu_Add_Off         : ALU adds latched operand to the read value
//   o_IR_Fetch            : load IR from the data bus
//   o_Reset_Cycle         : instruction completes this step
//   o_Illegal             : one-cycle reject pulse
// -----------------------------------------------------------------------------
module reg16_move_sequencer
   import reg16_move_sequencer_pkg::*;
#(
   parameter  int REG_COUNT   = 6,
   parameter  int STEPS_PER_M = 4,
   parameter  int PC_INDEX    = DEFAULT_PC_INDEX,
   parameter  int SP_INDEX    = DEFAULT_SP_INDEX,
   localparam int IW          = $clog2(REG_COUNT)
) (
   input  logic                 i_Clk,
   input  logic                 i_Reset,
   input  logic                 i_Start,
   input  logic [1:0]           i_Mode,
   input  logic [IW-1:0]        i_Src,
   input  logic [IW-1:0]        i_Dst,
   input  logic                 i_Mem_Ready,
   output logic                 o_Busy,
   output logic [REG_COUNT-1:0] o_Read16,
   output logic [REG_COUNT-1:0] o_Write16,
   output logic                 o_Address_Out,
   output logic [1:0]           o_Increment16,
   output logic                 o_Alu_Add_Off,
   output logic                 o_IR_Fetch,
   output logic                 o_Reset_Cycle,
   output logic                 o_Illegal
);

`ifdef REG16_SEQ_ADDOFF_EN
   localparam bit ADDOFF_EN = 1'b1;
`else
   localparam bit ADDOFF_EN = 1'b0;
`endif

   localparam logic [REG_COUNT-1:0] ONE    = REG_COUNT'(1);
   localparam logic [REG_COUNT-1:0] PC_SEL = ONE << PC_INDEX;
   localparam logic [REG_COUNT-1:0] SP_SEL = ONE << SP_INDEX;

   state_e        state_q, state_d;
   mode_e         mode_q;
   logic [IW-1:0] src_q, dst_q;
   logic          illegal_q;
   logic          start_legal;
   logic          step_last;
   logic          advance;
   logic          stall;

   // Shifting a single 1 keeps the selects one-hot; an out-of-range index
   // (never latched) would simply shift out to zero.
   wire [REG_COUNT-1:0] src_sel = ONE << src_q;
   wire [REG_COUNT-1:0] dst_sel = ONE << dst_q;

   assign start_legal = (mode_e'(i_Mode) != MODE_RSVD)
                     && (ADDOFF_EN || mode_e'(i_Mode) != MODE_ADDOFF)
                     && (int'(i_Src) < REG_COUNT)
                     && (int'(i_Dst) < REG_COUNT);

   // Only bus cycles can be held off by the memory.
   assign stall = o_Address_Out && !i_Mem_Ready;

   seq_step_counter #(
      .STEPS_PER_M (STEPS_PER_M)
   ) u_step (
      .i_Clk     (i_Clk),
      .i_Reset   (i_Reset),
      .i_Run     (state_q != ST_IDLE),
      .i_Stall   (stall),
      .o_Last    (step_last),
      .o_Advance (advance)
   );

   // State register plus launch latches.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_MOVE;
         src_q     <= '0;
         dst_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= (state_q == ST_IDLE) && i_Start && !start_legal;
         if ((state_q == ST_IDLE) && i_Start && start_legal) begin
            mode_q <= mode_e'(i_Mode);
            src_q  <= i_Src;
            dst_q  <= i_Dst;
         end
      end
   end

   // Next-state logic.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_Start && start_legal) begin
               case (mode_e'(i_Mode))
                  MODE_MOVE:   state_d = ST_EXECUTE;
                  MODE_JUMP:   state_d = ST_FETCH;
`ifdef REG16_SEQ_ADDOFF_EN
                  MODE_ADDOFF: state_d = ST_OPERAND;
`endif
                  default:     state_d = ST_IDLE;
               endcase
            end
         end
`ifdef REG16_SEQ_ADDOFF_EN
         ST_OPERAND: if (advance) state_d = ST_EXECUTE;
`endif
         ST_EXECUTE: if (advance) state_d = ST_FETCH;
         ST_FETCH:   if (advance) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Output decode from state and step.
   always_comb begin
      o_Busy        = (state_q != ST_IDLE);
      o_Read16      = '0;
      o_Write16     = '0;
      o_Address_Out = 1'b0;
      o_Increment16 = INC_NONE;
      o_Alu_Add_Off = 1'b0;
      o_IR_Fetch    = 1'b0;
      o_Reset_Cycle = 1'b0;
      o_Illegal     = illegal_q;
      case (state_q)
`ifdef REG16_SEQ_ADDOFF_EN
         ST_OPERAND: begin
            // Fetch the offset operand at PC and step past it.
            o_Read16      = PC_SEL;
            o_Address_Out = 1'b1;
            o_Increment16 = INC_UP;
         end
`endif
         ST_EXECUTE: begin
            if (ADDOFF_EN && mode_q == MODE_ADDOFF) begin
               o_Read16      = SP_SEL;
               o_Alu_Add_Off = 1'b1;
            end else begin
               o_Read16 = src_sel;
            end
            if (step_last) o_Write16 = dst_sel;
         end
         ST_FETCH: begin
            // JUMP fetches through the target register and copies it to PC.
            o_Read16      = (mode_q == MODE_JUMP) ? src_sel : PC_SEL;
            o_Address_Out = 1'b1;
            o_Increment16 = INC_UP;
            if (step_last) begin
               o_IR_Fetch    = 1'b1;
               o_Reset_Cycle = 1'b1;
               if (mode_q == MODE_JUMP) o_Write16 = PC_SEL;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reg16_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg16_move_sequencer
// Directed bench: a default-parameter instance checked every cycle against
// hand-derived timing, plus a REG_COUNT=8 / STEPS_PER_M=2 instance.
// -----------------------------------------------------------------------------
module tb_reg16_move_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- default instance ----------------
   logic       start = 1'b0;
   logic [1:0] mode  = 2'b00;
   logic [2:0] src   = 3'd0;
   logic [2:0] dst   = 3'd0;
   logic       ready = 1'b1;
   logic       busy_a, addr_a, alu_a, ir_a, rc_a, ill_a;
   logic [5:0] rd_a, wr_a;
   logic [1:0] inc_a;

   reg16_move_sequencer u_dut (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_Start       (start),
      .i_Mode        (mode),
      .i_Src         (src),
      .i_Dst         (dst),
      .i_Mem_Ready   (ready),
      .o_Busy        (busy_a),
      .o_Read16      (rd_a),
      .o_Write16     (wr_a),
      .o_Address_Out (addr_a),
      .o_Increment16 (inc_a),
      .o_Alu_Add_Off (alu_a),
      .o_IR_Fetch    (ir_a),
      .o_Reset_Cycle (rc_a),
      .o_Illegal     (ill_a)
   );

   // ---------------- REG_COUNT=8, STEPS_PER_M=2 instance ----------------
   logic       start_b = 1'b0;
   logic [1:0] mode_b  = 2'b00;
   logic [2:0] src_b   = 3'd0;
   logic [2:0] dst_b   = 3'd0;
   logic       busy_b, addr_b, alu_b, ir_b, rc_b, ill_b;
   logic [7:0] rd_b, wr_b;
   logic [1:0] inc_b;

   reg16_move_sequencer #(
      .REG_COUNT   (8),
      .STEPS_PER_M (2)
   ) u_dut_b (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_Start       (start_b),
      .i_Mode        (mode_b),
      .i_Src         (src_b),
      .i_Dst         (dst_b),
      .i_Mem_Ready   (1'b1),
      .o_Busy        (busy_b),
      .o_Read16      (rd_b),
      .o_Write16     (wr_b),
      .o_Address_Out (addr_b),
      .o_Increment16 (inc_b),
      .o_Alu_Add_Off (alu_b),
      .o_IR_Fetch    (ir_b),
      .o_Reset_Cycle (rc_b),
      .o_Illegal     (ill_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic busy, input logic [5:0] rd, input logic [5:0] wr,
                                        input logic addr, input logic [1:0] inc, input logic alu,
                                        input logic ir, input logic rc, input logic ill);
      return {12'd0, busy, rd, wr, addr, inc, alu, ir, rc, ill};
   endfunction

   wire [31:0] obs_a = {12'd0, busy_a, rd_a, wr_a, addr_a, inc_a, alu_a, ir_a, rc_a, ill_a};
   wire [31:0] obs_b = {20'd0, busy_b, wr_b, ir_b, rc_b, ill_b};

   localparam logic [5:0] PC_OH = 6'b010000;
   localparam logic [5:0] SP_OH = 6'b001000;

   // Expected outputs at busy cycle c (1-based) of an op on the default
   // instance. The first M-cycle is stretched by 'stall' cycles on its last
   // step; later M-cycles are 4 steps each.
   function automatic logic [31:0] expect_vec(input logic [1:0] m, input int s, input int d,
                                              input int c, input int stall);
      int        ph [3];
      int        nph, p, k, len0;
      logic      last;
      logic [5:0] s_oh, d_oh;
      s_oh = 6'b000001 << s;
      d_oh = 6'b000001 << d;
      case (m)
         2'b00:   begin ph = '{2, 3, 0}; nph = 2; end // EXECUTE, FETCH
         2'b01:   begin ph = '{3, 0, 0}; nph = 1; end // FETCH
         default: begin ph = '{1, 2, 3}; nph = 3; end // OPERAND, EXECUTE, FETCH
      endcase
      len0 = 4 + stall;
      if (c < 1) return 32'd0;
      k = c - 1;
      if (k < len0) begin
         p    = 0;
         last = (k >= 3);
      end else begin
         k    = k - len0;
         p    = 1 + k / 4;
         last = ((k % 4) == 3);
      end
      if (p >= nph) return 32'd0;
      case (ph[p])
         1: return pack(1'b1, PC_OH, 6'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
         2: begin
            if (m == 2'b10)
               return pack(1'b1, SP_OH, last ? d_oh : 6'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
            return pack(1'b1, s_oh, last ? d_oh : 6'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         default: begin
            if (m == 2'b01)
               return pack(1'b1, s_oh, last ? PC_OH : 6'd0, 1'b1, 2'b01, 1'b0, last, last, 1'b0);
            return pack(1'b1, PC_OH, 6'd0, 1'b1, 2'b01, 1'b0, last, last, 1'b0);
         end
      endcase
   endfunction

   // Launch an op and check every busy cycle plus the first idle cycle after.
   // 'poke' > 0 fires a conflicting JUMP start at that busy cycle.
   task automatic run_op(input string name, input logic [1:0] m, input int s, input int d,
                         input int stall, input int cycles, input int poke);
      @(negedge clk);
      mode  = m;
      src   = 3'(s);
      dst   = 3'(d);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= cycles + 1; c++) begin
         ready = !(c >= 4 && c < 4 + stall);
         check($sformatf("%s cyc%0d", name, c), obs_a, expect_vec(m, s, d, c, stall));
         if (c == poke) begin
            start = 1'b1;
            mode  = 2'b01;
            src   = 3'd0;
            dst   = 3'd5;
         end
         @(negedge clk);
         start = 1'b0;
      end
      ready = 1'b1;
   endtask

   task automatic run_illegal(input string name, input logic [1:0] m, input int s, input int d);
      @(negedge clk);
      mode  = m;
      src   = 3'(s);
      dst   = 3'(d);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, " pulse"}, obs_a, pack(1'b0, 6'd0, 6'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
      @(negedge clk);
      check({name, " after"}, obs_a, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state, while reset is held.
      #1;
      check("reset_a", obs_a, 32'd0);
      check("reset_b", obs_b, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // MOVE 2 -> 3: 8 busy cycles, write 001000 at cycle 4, IR fetch at 8.
      run_op("move23", 2'b00, 2, 3, 0, 8, 0);
      // Src == Dst, with a start pulse while busy that must be ignored.
      run_op("move11_poke", 2'b00, 1, 1, 0, 8, 3);
      // JUMP through register 2, no wait states.
      run_op("jump2", 2'b01, 2, 0, 0, 4, 0);
      // JUMP with the bus holding off the last step for 2 cycles.
      run_op("jump5_stall", 2'b01, 5, 0, 2, 6, 0);

`ifdef REG16_SEQ_ADDOFF_EN
      // ADDOFF Dst=2 with 3 wait states on the operand read: 15 busy cycles.
      run_op("addoff2", 2'b10, 0, 2, 3, 15, 0);
`else
      run_illegal("addoff_disabled", 2'b10, 0, 2);
`endif

      run_illegal("mode11", 2'b11, 1, 2);
      run_illegal("src7", 2'b00, 7, 2);
      run_illegal("dst6", 2'b01, 0, 6);

      // Async reset at MOVE cycle 5, then a clean MOVE.
      @(negedge clk);
      mode  = 2'b00;
      src   = 3'd2;
      dst   = 3'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_reset cyc5", obs_a, expect_vec(2'b00, 2, 3, 5, 0));
      #1 rst = 1'b1;
      #1 check("async_reset", obs_a, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("move23_after_reset", 2'b00, 2, 3, 0, 8, 0);

      // REG_COUNT=8, STEPS_PER_M=2: MOVE 6 -> 7 takes 4 cycles.
      @(negedge clk);
      mode_b  = 2'b00;
      src_b   = 3'd6;
      dst_b   = 3'd7;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      check("b_move cyc1", obs_b, {20'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      check("b_move cyc2", obs_b, {20'd0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      check("b_move cyc3", obs_b, {20'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      check("b_move cyc4", obs_b, {20'd0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0});
      @(negedge clk);
      check("b_move idle", obs_b, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
